// File: rtl/ram_arb_pkg.sv
// Shared sizes, word/address types and the round-robin pointer update used by
// the RAM arbiter and its per-port arbiters.
package ram_arb_pkg;

  localparam int DEF_NUM_REQ   = 2;
  localparam int DEF_ADDR_SIZE = 11;
  localparam int DEF_DATA_SIZE = 9;

  typedef logic [DEF_ADDR_SIZE-1:0] addr_t;
  typedef logic [DEF_DATA_SIZE-1:0] data_t;

  // Pointer moves just past the winner; with no winner it stays put.
  function automatic int unsigned rr_next(input int unsigned ptr,
                                          input int unsigned grant_idx,
                                          input logic        granted,
                                          input int unsigned n);
    if (!granted) return ptr;
    return (grant_idx + 1) % n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant from the valids and a registered priority
// pointer; grants are forced low while rst is high.
module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] valid_i,
  output logic [N-1:0] grant_o
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;
  logic [PTR_W-1:0] gidx;
  logic [PTR_W-1:0] sel;
  logic             found;
  int unsigned      idx;

  always_comb begin
    grant_o = '0;
    gidx    = '0;
    sel     = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (32'(ptr_q) + 32'(k)) % 32'(N);
      sel = PTR_W'(idx);
      if (!found && valid_i[sel]) begin
        found        = 1'b1;
        gidx         = sel;
        grant_o[sel] = 1'b1;
      end
    end
    if (rst) begin
      grant_o = '0;
    end
    ptr_d = PTR_W'(rr_next(32'(ptr_q), 32'(gidx), found, 32'(N)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one simple dual-port RAM (registered read, 1-cycle latency) between
// NUM_REQ requesters with independent round-robin read and write arbitration.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int DATA_SIZE = DEF_DATA_SIZE
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                rd_req_valid,
  input  logic [NUM_REQ-1:0][ADDR_SIZE-1:0] rd_req_addr,
  output logic [NUM_REQ-1:0]                rd_req_ready,
  output logic [NUM_REQ-1:0]                rd_rsp_valid,
  output logic [DATA_SIZE-1:0]              rd_rsp_data,
  input  logic [NUM_REQ-1:0]                wr_req_valid,
  input  logic [NUM_REQ-1:0][ADDR_SIZE-1:0] wr_req_addr,
  input  logic [NUM_REQ-1:0][DATA_SIZE-1:0] wr_req_data,
  output logic [NUM_REQ-1:0]                wr_req_ready,
  output logic [ADDR_SIZE-1:0]              ram_r_addr,
  output logic [ADDR_SIZE-1:0]              ram_w_addr,
  output logic                              ram_wren,
  output logic [DATA_SIZE-1:0]              ram_wdata,
  input  logic [DATA_SIZE-1:0]              ram_rdata
);

  logic [NUM_REQ-1:0]   rd_gnt;
  logic [NUM_REQ-1:0]   wr_gnt;
  logic [ADDR_SIZE-1:0] rd_addr_mux;
  logic [ADDR_SIZE-1:0] wr_addr_mux;
  logic [DATA_SIZE-1:0] wr_data_mux;
  logic [ADDR_SIZE-1:0] r_addr_q;
  logic [ADDR_SIZE-1:0] r_addr_d;
  logic [NUM_REQ-1:0]   rsp_vld_q;
  logic [NUM_REQ-1:0]   rsp_vld_d;

  rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
    .clk     (clk),
    .rst     (rst),
    .valid_i (rd_req_valid),
    .grant_o (rd_gnt)
  );

  rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
    .clk     (clk),
    .rst     (rst),
    .valid_i (wr_req_valid),
    .grant_o (wr_gnt)
  );

  // Grants are one-hot, so an OR of the masked inputs is the mux.
  always_comb begin
    rd_addr_mux = '0;
    wr_addr_mux = '0;
    wr_data_mux = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rd_gnt[i]) rd_addr_mux = rd_addr_mux | rd_req_addr[i];
      if (wr_gnt[i]) begin
        wr_addr_mux = wr_addr_mux | wr_req_addr[i];
        wr_data_mux = wr_data_mux | wr_req_data[i];
      end
    end
  end

  always_comb begin
    r_addr_d  = (|rd_gnt) ? rd_addr_mux : r_addr_q;
    rsp_vld_d = rd_gnt;
  end

  // Grant stage -> response stage: RAM data arrives one edge after the grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr_q  <= '0;
      rsp_vld_q <= '0;
    end else begin
      r_addr_q  <= r_addr_d;
      rsp_vld_q <= rsp_vld_d;
    end
  end

  assign rd_req_ready = rd_gnt;
  assign wr_req_ready = wr_gnt;
  assign ram_r_addr   = r_addr_d;
  assign ram_w_addr   = wr_addr_mux;
  assign ram_wdata    = wr_data_mux;
  assign ram_wren     = |wr_gnt;
  assign rd_rsp_valid = rsp_vld_q;
  assign rd_rsp_data  = ram_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: two-requester instance against a behavioural RAM with a
// scoreboard of read responses, plus a three-requester instance for rotation/reset.
module tb_ram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Two-requester instance and its RAM
  logic             rst;
  logic [1:0]       rv, wv;
  logic [1:0][10:0] ra, wa;
  logic [1:0][8:0]  wd;
  logic [1:0]       rrdy, wrdy, rsp_v;
  logic [8:0]       rsp_d, wdata, rdata;
  logic [10:0]      raddr, waddr;
  logic             wren;
  logic [8:0]       mem [0:2047] = '{default: 9'h000};

  ram_arbiter #(.NUM_REQ(2), .ADDR_SIZE(11), .DATA_SIZE(9)) dut (
    .clk(clk), .rst(rst),
    .rd_req_valid(rv), .rd_req_addr(ra), .rd_req_ready(rrdy),
    .rd_rsp_valid(rsp_v), .rd_rsp_data(rsp_d),
    .wr_req_valid(wv), .wr_req_addr(wa), .wr_req_data(wd), .wr_req_ready(wrdy),
    .ram_r_addr(raddr), .ram_w_addr(waddr), .ram_wren(wren),
    .ram_wdata(wdata), .ram_rdata(rdata)
  );

  always @(posedge clk) begin
    if (wren) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

  // Three-requester instance (rotation and reset only)
  logic             rst3;
  logic [2:0]       rv3, wv3;
  logic [2:0][10:0] ra3, wa3;
  logic [2:0][8:0]  wd3;
  logic [2:0]       rrdy3, wrdy3, rsp_v3;
  logic [8:0]       rsp_d3, wdata3;
  logic [8:0]       rdata3 = 9'h000;
  logic [10:0]      raddr3, waddr3;
  logic             wren3;

  ram_arbiter #(.NUM_REQ(3), .ADDR_SIZE(11), .DATA_SIZE(9)) dut3 (
    .clk(clk), .rst(rst3),
    .rd_req_valid(rv3), .rd_req_addr(ra3), .rd_req_ready(rrdy3),
    .rd_rsp_valid(rsp_v3), .rd_rsp_data(rsp_d3),
    .wr_req_valid(wv3), .wr_req_addr(wa3), .wr_req_data(wd3), .wr_req_ready(wrdy3),
    .ram_r_addr(raddr3), .ram_w_addr(waddr3), .ram_wren(wren3),
    .ram_wdata(wdata3), .ram_rdata(rdata3)
  );

  // Reference model state
  typedef struct packed {
    logic [1:0] vld;
    logic [8:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [8:0]  shadow [0:2047] = '{default: 9'h000};
  int          rptr = 0;
  int          wptr = 0;
  logic [10:0] last_raddr = '0;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] pick2(input logic [1:0] v, input int p);
    for (int k = 0; k < 2; k++) begin
      if (v[(p + k) % 2]) return 2'b01 << ((p + k) % 2);
    end
    return 2'b00;
  endfunction

  // One cycle of the two-requester instance; inputs are already driven.
  task automatic tick();
    logic [1:0] eg_r, eg_w;
    exp_t       e;
    int         ri, wi;
    #4;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rsp_valid", 32'(rsp_v), 32'(e.vld));
      if (e.vld != 2'b00) chk("rsp_data", 32'(rsp_d), 32'(e.data));
    end
    eg_r = rst ? 2'b00 : pick2(rv, rptr);
    eg_w = rst ? 2'b00 : pick2(wv, wptr);
    ri   = eg_r[1] ? 1 : 0;
    wi   = eg_w[1] ? 1 : 0;
    chk("rd_ready", 32'(rrdy), 32'(eg_r));
    chk("wr_ready", 32'(wrdy), 32'(eg_w));
    chk("wren", 32'(wren), 32'(|eg_w));
    if (eg_r != 2'b00) chk("ram_r_addr", 32'(raddr), 32'(ra[ri]));
    else if (!rst)     chk("r_addr_hold", 32'(raddr), 32'(last_raddr));
    if (eg_w != 2'b00) begin
      chk("ram_w_addr", 32'(waddr), 32'(wa[wi]));
      chk("ram_wdata", 32'(wdata), 32'(wd[wi]));
    end
    e.vld  = eg_r;
    e.data = (eg_r != 2'b00) ? shadow[ra[ri]] : 9'h000;
    sb.push_back(e);
    if (eg_w != 2'b00) shadow[wa[wi]] = wd[wi];
    if (rst) begin
      rptr = 0; wptr = 0; last_raddr = '0;
    end else begin
      if (eg_r != 2'b00) begin rptr = (ri + 1) % 2; last_raddr = ra[ri]; end
      if (eg_w != 2'b00) wptr = (wi + 1) % 2;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick3(input string tag, input logic [2:0] exp_g);
    #4;
    chk({tag, "_rd"}, 32'(rrdy3), 32'(exp_g));
    chk({tag, "_wr"}, 32'(wrdy3), 32'(exp_g));
    chk({tag, "_wren"}, 32'(wren3), 32'(|exp_g));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] seq_run [0:3];
    logic [2:0] seq_restart [0:2];
    seq_run     = '{3'b001, 3'b010, 3'b100, 3'b001};
    seq_restart = '{3'b001, 3'b010, 3'b100};

    rst  = 1'b1; rst3 = 1'b1;
    rv   = 2'b11; wv = 2'b11;
    ra[0] = 11'h100; ra[1] = 11'h101;
    wa[0] = 11'h200; wa[1] = 11'h201;
    wd[0] = 9'h0A0;  wd[1] = 9'h0A1;
    rv3 = 3'b111; wv3 = 3'b111;
    for (int i = 0; i < 3; i++) begin
      ra3[i] = 11'(i); wa3[i] = 11'(16 + i); wd3[i] = 9'(i);
    end

    // Reset with everything requesting, then first grant goes to requester 0
    repeat (3) tick();
    rst = 1'b0;
    tick();
    rv = 2'b00; wv = 2'b00;
    tick();

    // Write then read back through requester 1
    wv = 2'b10; wa[1] = 11'h005; wd[1] = 9'h1A5;
    tick();
    wv = 2'b00; rv = 2'b10; ra[1] = 11'h005;
    tick();
    rv = 2'b00;
    tick();

    // Preload, then alternating reads from both requesters
    wv = 2'b11; wa[0] = 11'h010; wd[0] = 9'h011; wa[1] = 11'h020; wd[1] = 9'h022;
    repeat (2) tick();
    wv = 2'b00; rv = 2'b11; ra[0] = 11'h010; ra[1] = 11'h020;
    repeat (6) tick();
    rv = 2'b00;
    tick();

    // Same-cycle read and write of one address returns the old word
    wv = 2'b01; wa[0] = 11'h033; wd[0] = 9'h011;
    tick();
    wd[0] = 9'h0FF; rv = 2'b10; ra[1] = 11'h033;
    tick();
    wv = 2'b00;
    tick();
    rv = 2'b00;
    tick();

    // Both requesters writing every cycle, then read everything back
    wv = 2'b11;
    for (int i = 0; i < 6; i++) begin
      wa[0] = 11'h300 + 11'(i); wd[0] = 9'h100 + 9'(i);
      wa[1] = 11'h380 + 11'(i); wd[1] = 9'h080 + 9'(i);
      tick();
    end
    wv = 2'b00; rv = 2'b01;
    for (int i = 0; i < 6; i++) begin
      ra[0] = 11'h300 + 11'(i); tick();
      ra[0] = 11'h380 + 11'(i); tick();
    end
    rv = 2'b00;
    tick();

    // Reset in the middle of traffic
    rv = 2'b11; wv = 2'b11;
    ra[0] = 11'h010; ra[1] = 11'h020; wa[0] = 11'h400; wa[1] = 11'h401;
    tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    rv = 2'b00; wv = 2'b00;
    repeat (2) tick();

    // Three requesters: rotation, reset pulse, restart from 0
    rst3 = 1'b0;
    for (int i = 0; i < 4; i++) tick3("rr3_run", seq_run[i]);
    rst3 = 1'b1;
    repeat (2) tick3("rr3_rst", 3'b000);
    rst3 = 1'b0;
    for (int i = 0; i < 3; i++) tick3("rr3_restart", seq_restart[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation did not finish");
  end

endmodule
